ycbcr_mac_seq: RTL and testbench
================================

YCBCR_MAC_SEQ -- requirements
Module: ycbcr_mac_seq

Interface
REQ-001 SHALL have parameter MAC_LAT, default 6: cycles from mac_dvalid high to the MAC channels' dvalid_out high.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of RGB result entries; must be a power of two, at least 2.
REQ-003 clk  input  1  the single clock; all logic is rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pix_valid  input  1  an input pixel is offered.
REQ-006 pix_ready  output  1  the block accepts the offered pixel this cycle.
REQ-007 pix_data  input  24  {Y[23:16], Cb[15:8], Cr[7:0]}.
REQ-008 mac_dvalid  output  1  start-of-pixel pulse to dvalid_in of all three MAC channels.
REQ-009 mac_vdata  output  8  serialized component byte to vdata_in of all three MAC channels.
REQ-010 mac_clk_en  output  1  clock enable to all three MAC channels.
REQ-011 r_dvalid, g_dvalid, b_dvalid  input  1 each  MAC channel result-valid signals.
REQ-012 r_data, g_data, b_data  input  8 each  MAC channel saturated results.
REQ-013 rgb_valid  output  1  result FIFO is not empty.
REQ-014 rgb_ready  input  1  downstream consumes the FIFO head.
REQ-015 rgb_data  output  24  {R, G, B} at the FIFO head.
REQ-016 busy  output  1  sequencer not IDLE, or inflight > 0.
REQ-017 align_err  output  1  sticky; the r/g/b dvalid inputs disagreed.
REQ-018 overflow  output  1  sticky; a push was attempted into a full FIFO.

Function
REQ-019 The sequencer SHALL use states IDLE, P0, P1, P2 and emit one component per cycle.
REQ-020 A pixel SHALL be accepted when pix_valid and pix_ready are both high; its bytes SHALL be latched into a holding register.
REQ-021 pix_ready SHALL equal (state is IDLE or P2) AND credit > 0, where credit = FIFO_DEPTH - fifo_count - inflight.
REQ-022 Transitions SHALL be:
- IDLE -> P0 on accept, else stay in IDLE;
- P0 -> P1;
- P1 -> P2;
- P2 -> P0 on accept, else -> IDLE.
REQ-023 mac_vdata SHALL be Y in P0, Cb in P1, Cr in P2, and 0x00 in IDLE.
REQ-024 mac_dvalid SHALL be high only during P0, for exactly one cycle per pixel.
REQ-025 Back-to-back accepts SHALL yield one pixel every 3 cycles with no idle gap.
REQ-026 mac_clk_en SHALL equal busy.
REQ-027 inflight SHALL increment on mac_dvalid and decrement on each result push; increment and decrement in the same cycle SHALL leave it unchanged.
REQ-028 inflight SHALL be sized to hold FIFO_DEPTH.
REQ-029 When r_dvalid, g_dvalid and b_dvalid are all high, {r_data, g_data, b_data} SHALL be pushed in that cycle.
REQ-030 If some but not all of r_dvalid, g_dvalid, b_dvalid are high, align_err SHALL set, there SHALL be no push, and inflight SHALL be unchanged.
REQ-031 FIFO pop SHALL occur on rgb_valid AND rgb_ready.
REQ-032 Simultaneous push and pop SHALL be legal even when the FIFO is full; fifo_count is then unchanged and order is preserved.
REQ-033 A push into a full FIFO with no pop SHALL set overflow and drop the data. The credit rule makes this unreachable in legal operation.
REQ-034 Pointer wrap-around SHALL be modulo FIFO_DEPTH.
REQ-035 rgb_data SHALL be combinationally the FIFO head. Its value is don't-care when rgb_valid is low.
REQ-036 Accept-to-result latency SHALL be 1 + MAC_LAT cycles to the push, with rgb_valid high the cycle after the push.

Reset
REQ-037 While rst is high, the block SHALL reset asynchronously:
- state IDLE; holding register, inflight and FIFO pointers 0;
- pix_ready, mac_dvalid, mac_clk_en, rgb_valid, busy, align_err and overflow all 0;
- mac_vdata and rgb_data 0x00 / 0x000000.
REQ-038 Reset asserted mid-pixel or mid-drain SHALL discard all partial and queued data.
REQ-039 After rst deasserts, the first accepted pixel SHALL behave as in REQ-036.
REQ-040 align_err and overflow SHALL clear only on rst.

Verification
REQ-041 Single pixel 0x8010F0, model MAC_LAT=6 -> mac_vdata 0x80, 0x10, 0xF0 on three consecutive cycles; mac_dvalid high on the 0x80 cycle only; rgb_valid 8 cycles after accept.
REQ-042 Five back-to-back pixels with rgb_ready=1 -> accepts 3 cycles apart; rgb_data outputs in input order; busy drops after the last pop.
REQ-043 rgb_ready=0 with continuous pix_valid -> exactly 4 accepts; pix_ready then stays 0; overflow stays 0; the 4 entries drain in order after rgb_ready=1.
REQ-044 Force r_dvalid=1 with g_dvalid=0 for one cycle -> align_err=1 and sticky; fifo_count unchanged.
REQ-045 Assert rst in P1 of pixel 2 with pixel 1 in flight -> all outputs 0 immediately; no rgb_valid afterward until a new pixel is accepted.
REQ-046 FIFO full, rgb_ready=1 and a result arriving in the same cycle -> fifo_count stays 4; overflow=0; the new entry appears last.

Source files
------------

// File: rtl/ycbcr_mac_seq.sv
// ycbcr_mac_seq: serializes YCbCr pixels into three shared MAC channels
// (Y, Cb, Cr on consecutive cycles) and collects the aligned R/G/B results
// into a small FIFO. Input acceptance is credit-gated, so every pixel sent
// into the MAC pipe is guaranteed a FIFO slot.
module ycbcr_mac_seq #(
    parameter int MAC_LAT    = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_data,
    output logic        mac_dvalid,
    output logic [7:0]  mac_vdata,
    output logic        mac_clk_en,
    input  logic        r_dvalid,
    input  logic        g_dvalid,
    input  logic        b_dvalid,
    input  logic [7:0]  r_data,
    input  logic [7:0]  g_data,
    input  logic [7:0]  b_data,
    output logic        rgb_valid,
    input  logic        rgb_ready,
    output logic [23:0] rgb_data,
    output logic        busy,
    output logic        align_err,
    output logic        overflow
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = $clog2(FIFO_DEPTH + 1);
    // The credit rule caps inflight at FIFO_DEPTH; the MAC pipe itself can
    // hold at most about MAC_LAT/3 pixels. Size for the larger bound.
    localparam int PIPE_PIX = MAC_LAT / 3 + 2;
    localparam int INF_MAX  = (FIFO_DEPTH > PIPE_PIX) ? FIFO_DEPTH : PIPE_PIX;
    localparam int IW       = $clog2(INF_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_P0   = 2'd1;
    localparam logic [1:0] S_P1   = 2'd2;
    localparam logic [1:0] S_P2   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [23:0]   hold_q;
    logic [IW-1:0] infl_q, infl_d;
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic [23:0]   mem_q [FIFO_DEPTH];
    logic          align_q, ovf_q;
    logic          accept, room, all_dv, any_dv, full, push, pop, dec;

    assign room       = (32'(cnt_q) + 32'(infl_q)) < 32'(FIFO_DEPTH);
    assign pix_ready  = !rst && (state_q == S_IDLE || state_q == S_P2) && room;
    assign accept     = pix_valid && pix_ready;
    assign mac_dvalid = (state_q == S_P0);
    assign busy       = (state_q != S_IDLE) || (infl_q != '0);
    assign mac_clk_en = busy;

    assign all_dv    = r_dvalid & g_dvalid & b_dvalid;
    assign any_dv    = r_dvalid | g_dvalid | b_dvalid;
    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    assign rgb_valid = (cnt_q != '0);
    assign pop       = rgb_valid && rgb_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still push.
    assign push      = all_dv && (!full || pop);
    // Saturate at zero so a spurious result can never wrap the counter.
    assign dec       = push && (infl_q != '0);
    assign rgb_data  = rgb_valid ? mem_q[rd_q] : 24'h0;
    assign align_err = align_q;
    assign overflow  = ovf_q;

    // Component mux: one byte of the held pixel per sequencer state.
    always_comb begin
        mac_vdata = 8'h00;
        case (state_q)
            S_P0:    mac_vdata = hold_q[23:16];
            S_P1:    mac_vdata = hold_q[15:8];
            S_P2:    mac_vdata = hold_q[7:0];
            default: mac_vdata = 8'h00;
        endcase
    end

    // Sequencer next state; P2 chains straight into P0 for back-to-back pixels.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_P0 : S_IDLE;
            S_P0:    state_d = S_P1;
            S_P1:    state_d = S_P2;
            S_P2:    state_d = accept ? S_P0 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Inflight tracking: +1 per pixel launched, -1 per result pushed.
    always_comb begin
        infl_d = infl_q;
        case ({mac_dvalid, dec})
            2'b10:   infl_d = infl_q + IW'(1);
            2'b01:   infl_d = infl_q - IW'(1);
            default: infl_d = infl_q;
        endcase
    end

    // Control state, holding register, FIFO pointers and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            infl_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            align_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            infl_q  <= infl_d;
            if (accept) hold_q <= pix_data;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (any_dv && !all_dv)        align_q <= 1'b1;
            if (all_dv && full && !pop)   ovf_q   <= 1'b1;
        end
    end

    // Result storage; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {r_data, g_data, b_data};
    end

endmodule

// File: tb/tb_ycbcr_mac_seq.sv
// Bench for ycbcr_mac_seq: behavioural MAC channel model plus a result
// scoreboard fed at pixel accept and drained at each FIFO pop.
module tb_ycbcr_mac_seq;
    localparam int MAC_LAT    = 6;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        pix_valid = 1'b0, pix_ready;
    logic [23:0] pix_data = '0;
    logic        mac_dvalid, mac_clk_en;
    logic [7:0]  mac_vdata;
    logic        r_dvalid, g_dvalid, b_dvalid;
    logic [7:0]  r_data, g_data, b_data;
    logic        rgb_valid, rgb_ready = 1'b0;
    logic [23:0] rgb_data;
    logic        busy, align_err, overflow;

    // Bench-side stimulus overrides of the MAC outputs
    logic        frc_r = 1'b0, inj = 1'b0;
    logic [23:0] inj_data = '0;

    int checks = 0, errors = 0, ncyc = 0, acc_n = 0;
    logic [23:0] exp_q [$];
    int          acc_cyc [$];
    logic [23:0] px [5] = '{24'h102030, 24'hFF00FF, 24'h7F8081, 24'h00FF01, 24'hC35A96};

    ycbcr_mac_seq #(.MAC_LAT(MAC_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .mac_dvalid(mac_dvalid), .mac_vdata(mac_vdata),
        .mac_clk_en(mac_clk_en), .r_dvalid(r_dvalid), .g_dvalid(g_dvalid),
        .b_dvalid(b_dvalid), .r_data(r_data), .g_data(g_data), .b_data(b_data),
        .rgb_valid(rgb_valid), .rgb_ready(rgb_ready), .rgb_data(rgb_data),
        .busy(busy), .align_err(align_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mac_fn(input logic [23:0] p);
        return {p[23:16] ^ p[7:0], p[23:16] + p[15:8], p[15:8] - p[7:0]};
    endfunction

    // MAC channel model: result valid MAC_LAT cycles after dvalid_in
    logic [MAC_LAT-1:0]      dv_sr;
    logic [MAC_LAT-1:0][7:0] vd_sr;
    logic [23:0]             model_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_sr <= '0;
            vd_sr <= '0;
        end else begin
            dv_sr <= {dv_sr[MAC_LAT-2:0], mac_dvalid};
            vd_sr <= {vd_sr[MAC_LAT-2:0], mac_vdata};
        end
    end
    assign model_res = mac_fn({vd_sr[MAC_LAT-1], vd_sr[MAC_LAT-2], vd_sr[MAC_LAT-3]});
    assign r_dvalid  = dv_sr[MAC_LAT-1] | frc_r | inj;
    assign g_dvalid  = dv_sr[MAC_LAT-1] | inj;
    assign b_dvalid  = dv_sr[MAC_LAT-1] | inj;
    assign {r_data, g_data, b_data} = inj ? inj_data : model_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: settle inputs, log accept/pop into the scoreboard, go to next negedge
    task automatic cyc();
        logic [23:0] e;
        #1;
        if (pix_valid && pix_ready) begin
            exp_q.push_back(mac_fn(pix_data));
            acc_cyc.push_back(ncyc);
            acc_n++;
        end
        if (rgb_valid && rgb_ready) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("rgb_order", {8'h0, rgb_data}, {8'h0, e});
            end
        end
        @(negedge clk);
        ncyc++;
    endtask

    task automatic drain();
        int n = 0;
        rgb_ready = 1'b1;
        while ((exp_q.size() != 0 || rgb_valid) && n < 60) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 32'(n < 60), 32'd1);
    endtask

    // Single pixel from idle: serialization order and accept-to-rgb_valid latency
    task automatic one_pixel(input logic [23:0] p);
        int a0 = acc_n;
        rgb_ready = 1'b1;
        pix_data  = p;
        pix_valid = 1'b1;
        cyc();
        pix_valid = 1'b0;
        chk("single_accept", 32'(acc_n - a0), 32'd1);
        chk("p0_dvalid", 32'(mac_dvalid), 32'd1);
        chk("p0_vdata", 32'(mac_vdata), 32'(p[23:16]));
        cyc();
        chk("p1_dvalid", 32'(mac_dvalid), 32'd0);
        chk("p1_vdata", 32'(mac_vdata), 32'(p[15:8]));
        cyc();
        chk("p2_dvalid", 32'(mac_dvalid), 32'd0);
        chk("p2_vdata", 32'(mac_vdata), 32'(p[7:0]));
        cyc();
        chk("idle_vdata", 32'(mac_vdata), 32'h0);
        for (int k = 5; k <= 8; k++) begin
            cyc();
            chk("latency_rgb_valid", 32'(rgb_valid), 32'(k == 8));
        end
        drain();
        chk("single_busy_end", 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
        chk({tag, "_mac_dvalid"}, 32'(mac_dvalid), 32'd0);
        chk({tag, "_mac_vdata"}, 32'(mac_vdata), 32'd0);
        chk({tag, "_mac_clk_en"}, 32'(mac_clk_en), 32'd0);
        chk({tag, "_rgb_valid"}, 32'(rgb_valid), 32'd0);
        chk({tag, "_rgb_data"}, 32'(rgb_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_align_err"}, 32'(align_err), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int a0, g, hits;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single pixel
        one_pixel(24'h8010F0);

        // Five back-to-back pixels, downstream always ready
        acc_cyc.delete();
        a0 = acc_n;
        g = 0;
        pix_valid = 1'b1;
        while (acc_n - a0 < 5 && g < 100) begin
            pix_data = px[acc_n - a0];
            cyc();
            g++;
        end
        pix_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_n - a0), 32'd5);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        drain();
        chk("b2b_busy_end", 32'(busy), 32'd0);
        chk("b2b_clk_en_end", 32'(mac_clk_en), 32'd0);

        // Stalled downstream: credit limits accepts to FIFO_DEPTH
        rgb_ready = 1'b0;
        a0 = acc_n;
        pix_valid = 1'b1;
        repeat (40) begin
            pix_data = $urandom;
            cyc();
        end
        chk("stall_accepts", 32'(acc_n - a0), 32'(FIFO_DEPTH));
        chk("stall_pix_ready", 32'(pix_ready), 32'd0);
        chk("stall_overflow", 32'(overflow), 32'd0);
        chk("stall_rgb_valid", 32'(rgb_valid), 32'd1);
        pix_valid = 1'b0;
        drain();

        // Full FIFO: result arrives with a simultaneous pop, then without one
        rgb_ready = 1'b0;
        a0 = acc_n;
        pix_valid = 1'b1;
        repeat (40) begin
            pix_data = $urandom;
            cyc();
        end
        pix_valid = 1'b0;
        chk("full_accepts", 32'(acc_n - a0), 32'(FIFO_DEPTH));
        inj_data  = 24'hA5C33C;
        inj       = 1'b1;
        rgb_ready = 1'b1;
        exp_q.push_back(inj_data);
        cyc();
        inj       = 1'b0;
        rgb_ready = 1'b0;
        chk("fullpop_still_full", 32'(pix_ready), 32'd0);
        chk("fullpop_rgb_valid", 32'(rgb_valid), 32'd1);
        chk("fullpop_overflow", 32'(overflow), 32'd0);
        inj_data = 24'h123456;
        inj      = 1'b1;
        cyc();
        inj = 1'b0;
        chk("overflow_set", 32'(overflow), 32'd1);
        drain();
        chk("overflow_sticky", 32'(overflow), 32'd1);
        chk("inj_busy_end", 32'(busy), 32'd0);

        // Misaligned channel valids
        frc_r = 1'b1;
        cyc();
        frc_r = 1'b0;
        chk("align_set", 32'(align_err), 32'd1);
        chk("align_no_push", 32'(rgb_valid), 32'd0);
        chk("align_inflight", 32'(busy), 32'd0);
        repeat (3) cyc();
        chk("align_sticky", 32'(align_err), 32'd1);

        // Reset in P1 of pixel 2 while pixel 1 is in flight
        rgb_ready = 1'b1;
        a0 = acc_n;
        g = 0;
        pix_valid = 1'b1;
        while (acc_n - a0 < 2 && g < 20) begin
            pix_data = px[acc_n - a0];
            cyc();
            g++;
        end
        pix_valid = 1'b0;
        chk("rst_pre_accepts", 32'(acc_n - a0), 32'd2);
        cyc();                      // now in P1 of pixel 2
        chk("rst_pre_p1_vdata", 32'(mac_vdata), 32'(px[1][15:8]));
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        hits = 0;
        repeat (20) begin
            cyc();
            if (rgb_valid) hits++;
        end
        chk("postrst_no_rgb_valid", 32'(hits), 32'd0);
        one_pixel(24'h3CC3E1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
